// File: rtl/sram_controller_if.sv
// MEM-stage request/response bundle between the pipeline and the SRAM controller.
// The pipeline side is the master; the controller is the slave.
interface sram_controller_if;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic [31:0] address;
    logic [31:0] writeData;
    logic [31:0] readData;
    logic        SRAM_NOT_READY;

    modport master (
        output MEM_R_EN,
        output MEM_W_EN,
        output address,
        output writeData,
        input  readData,
        input  SRAM_NOT_READY
    );

    modport slave (
        input  MEM_R_EN,
        input  MEM_W_EN,
        input  address,
        input  writeData,
        output readData,
        output SRAM_NOT_READY
    );
endinterface

// File: rtl/sram_controller.sv
// Multi-cycle bridge from 32-bit MEM-stage loads/stores to a 16-bit async SRAM,
// splitting each word into LO/HI half accesses and stalling the pipeline meanwhile.
//
// state | meaning
// IDLE  | waiting for a request; write wins over read
// RD_LO | OE low, capture low half on last phase cycle
// RD_HI | OE low, capture high half on last phase cycle
// WR_LO | drive low half, WE low except last phase cycle
// WR_HI | drive high half, WE low except last phase cycle
// DONE  | one-cycle completion, stall released, back to IDLE
module sram_controller #(
    parameter int unsigned BASE_ADDR     = 1024,
    parameter int unsigned ACCESS_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    sram_controller_if.slave  mem,
    inout  wire  [15:0]       SRAM_DQ,
    output logic [17:0]       SRAM_ADDR,
    output logic              SRAM_WE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_CE_N,
    output logic              SRAM_UB_N,
    output logic              SRAM_LB_N
);

    localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

    if (ACCESS_CYCLES < 2) begin : g_bad_cfg
        $error("sram_controller: ACCESS_CYCLES must be at least 2");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD_LO = 3'd1,
        S_RD_HI = 3'd2,
        S_WR_LO = 3'd3,
        S_WR_HI = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [31:0]        r_read_data;
    logic               w_last;
    logic [16:0]        w_word;
    logic               w_half;
    logic               w_dq_oe;
    logic [15:0]        w_dq_out;

    assign w_last = (r_cnt == CNT_LAST);

    // The pipeline holds the request stable while stalled, so the map is combinational.
    assign w_word = 17'((mem.address - 32'(BASE_ADDR)) >> 2);

    // State register, phase counter and read capture.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_read_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (r_state == S_RD_LO && w_last) begin
                r_read_data[15:0] <= SRAM_DQ;
            end
            if (r_state == S_RD_HI && w_last) begin
                r_read_data[31:16] <= SRAM_DQ;
            end
        end
    end

    // Next-state logic; the counter clears whenever the state changes.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        case (r_state)
            S_IDLE: begin
                if (mem.MEM_W_EN) begin
                    w_state_nxt = S_WR_LO;
                end else if (mem.MEM_R_EN) begin
                    w_state_nxt = S_RD_LO;
                end
            end
            S_RD_LO: begin
                if (w_last) w_state_nxt = S_RD_HI;
                else        w_cnt_nxt   = r_cnt + CNT_W'(1);
            end
            S_RD_HI: begin
                if (w_last) w_state_nxt = S_DONE;
                else        w_cnt_nxt   = r_cnt + CNT_W'(1);
            end
            S_WR_LO: begin
                if (w_last) w_state_nxt = S_WR_HI;
                else        w_cnt_nxt   = r_cnt + CNT_W'(1);
            end
            S_WR_HI: begin
                if (w_last) w_state_nxt = S_DONE;
                else        w_cnt_nxt   = r_cnt + CNT_W'(1);
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // WE rises on the last phase cycle so address and data stay valid past the edge.
    always_comb begin
        w_half    = 1'b0;
        w_dq_oe   = 1'b0;
        w_dq_out  = 16'h0000;
        SRAM_WE_N = 1'b1;
        SRAM_OE_N = 1'b1;
        case (r_state)
            S_RD_LO: begin
                SRAM_OE_N = 1'b0;
            end
            S_RD_HI: begin
                w_half    = 1'b1;
                SRAM_OE_N = 1'b0;
            end
            S_WR_LO: begin
                w_dq_oe   = 1'b1;
                w_dq_out  = mem.writeData[15:0];
                SRAM_WE_N = w_last;
            end
            S_WR_HI: begin
                w_half    = 1'b1;
                w_dq_oe   = 1'b1;
                w_dq_out  = mem.writeData[31:16];
                SRAM_WE_N = w_last;
            end
            default: begin
                w_half = 1'b0;
            end
        endcase
    end

    assign SRAM_DQ   = w_dq_oe ? w_dq_out : 16'bz;
    assign SRAM_ADDR = {w_word, w_half};
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

    assign mem.readData       = r_read_data;
    assign mem.SRAM_NOT_READY = (mem.MEM_R_EN | mem.MEM_W_EN) & (r_state != S_DONE);

endmodule
